// File: rtl/rob_alloc_if.sv
// Dispatch <-> ROB allocation bundle: slot requests and commit count in,
// grants, entry addresses and occupancy status out.
// Handshake: req1_i/req2_i act as valid, dp1_o/dp2_o as same-cycle ready; an
// ungranted request is re-presented unchanged by dispatch until granted.
interface rob_alloc_if #(
  parameter int ROB_SEL = 6
);
  logic               req1_i;
  logic               req2_i;
  logic [1:0]         comnum_i;
  logic               flush_i;
  logic               dp1_o;
  logic               dp2_o;
  logic [ROB_SEL-1:0] dp1_addr_o;
  logic [ROB_SEL-1:0] dp2_addr_o;
  logic               stall_o;
  logic [ROB_SEL-1:0] head_o;
  logic [ROB_SEL:0]   free_cnt_o;
  logic               empty_o;
  logic               full_o;

  modport master (
    output req1_i, req2_i, comnum_i, flush_i,
    input  dp1_o, dp2_o, dp1_addr_o, dp2_addr_o, stall_o,
    input  head_o, free_cnt_o, empty_o, full_o
  );

  modport slave (
    input  req1_i, req2_i, comnum_i, flush_i,
    output dp1_o, dp2_o, dp1_addr_o, dp2_addr_o, stall_o,
    output head_o, free_cnt_o, empty_o, full_o
  );
endinterface

// File: rtl/rob_alloc_ctrl.sv
// ROB allocation controller: grants up to two in-order entries per cycle from
// registered occupancy, tracks head/tail/count and rewinds the tail on flush.
module rob_alloc_ctrl #(
  parameter int ROB_NUM = 64,
  parameter int ROB_SEL = 6
) (
  input  logic        clk_i,
  input  logic        reset_i,
  rob_alloc_if.slave  dp_if
);
  localparam logic [ROB_SEL:0] ROB_NUM_C = (ROB_SEL+1)'(ROB_NUM);

  logic [ROB_SEL-1:0] head_q, head_d;
  logic [ROB_SEL-1:0] tail_q, tail_d;
  logic [ROB_SEL:0]   cnt_q, cnt_d;

  logic [1:0]         need;
  logic [ROB_SEL:0]   free_cnt;
  logic [ROB_SEL:0]   alloc;
  logic               grant_ok;
  logic               dp1, dp2, stall;

  // Grant decision uses only registered occupancy; same-cycle commits are not credited.
  always_comb begin
    free_cnt = ROB_NUM_C - cnt_q;
    need     = {1'b0, dp_if.req1_i} + {1'b0, dp_if.req1_i & dp_if.req2_i};
    grant_ok = ((ROB_SEL+1)'(need) <= free_cnt) && !dp_if.flush_i;
    dp1      = grant_ok && dp_if.req1_i;
    dp2      = grant_ok && dp_if.req1_i && dp_if.req2_i;
    stall    = !grant_ok && (need != 2'd0);
    alloc    = (ROB_SEL+1)'(dp1) + (ROB_SEL+1)'(dp2);
  end

  always_comb begin
    head_d = head_q + ROB_SEL'(dp_if.comnum_i);
    tail_d = tail_q + alloc[ROB_SEL-1:0];
    cnt_d  = cnt_q + alloc - (ROB_SEL+1)'(dp_if.comnum_i);
    // Flush keeps this cycle's retirements, then discards everything younger.
    if (dp_if.flush_i) begin
      tail_d = head_d;
      cnt_d  = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  assign dp_if.dp1_o      = dp1;
  assign dp_if.dp2_o      = dp2;
  assign dp_if.stall_o    = stall;
  assign dp_if.dp1_addr_o = tail_q;
  assign dp_if.dp2_addr_o = tail_q + ROB_SEL'(1);
  assign dp_if.head_o     = head_q;
  assign dp_if.free_cnt_o = free_cnt;
  assign dp_if.empty_o    = (cnt_q == '0);
  assign dp_if.full_o     = (cnt_q == ROB_NUM_C);
endmodule

// File: tb/tb_rob_alloc_ctrl.sv
// Bench for rob_alloc_ctrl: directed scenarios plus random traffic, checked
// against a queue-of-live-entries reference model through an expected queue.
module tb_rob_alloc_ctrl;
  localparam int N = 64;
  localparam int S = 6;
  localparam int W = 5 + 3*S + (S+1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rob_alloc_if #(.ROB_SEL(S)) bus ();

  rob_alloc_ctrl #(.ROB_NUM(N), .ROB_SEL(S)) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .dp_if   (bus.slave)
  );

  logic [W-1:0] exp_q[$];
  string        tag_q[$];
  int           n_chk  = 0;
  int           n_pass = 0;
  bit           proto_ok = 1'b0;

  // Reference model: the ROB as a list of live entry addresses, oldest first.
  int live_q[$];
  int m_head = 0;
  int m_tail = 0;

  function automatic logic [W-1:0] pack(input bit g1, g2, st, em, fu,
                                         input int a1, a2, hd, fr);
    logic [S-1:0] a1v, a2v, hdv;
    logic [S:0]   frv;
    a1v = S'(a1);
    a2v = S'(a2);
    hdv = S'(hd);
    frv = (S+1)'(fr);
    return {g1, g2, st, em, fu, a1v, a2v, hdv, frv};
  endfunction

  task automatic cycle(input bit r1, input bit r2, input int cm, input bit fl,
                       input bit rs, input string tag);
    int  occ, free, need;
    bit  g1, g2, st;
    bus.req1_i   = r1;
    bus.req2_i   = r2;
    bus.comnum_i = 2'(cm);
    bus.flush_i  = fl;
    rst          = rs;
    occ  = live_q.size();
    free = N - occ;
    need = (r1 ? 1 : 0) + ((r1 && r2) ? 1 : 0);
    g1 = 0; g2 = 0; st = 0;
    if (need > 0) begin
      if (need <= free && !fl) begin
        g1 = 1;
        g2 = (need == 2);
      end else begin
        st = 1;
      end
    end
    exp_q.push_back(pack(g1, g2, st, occ == 0, occ == N, m_tail, (m_tail + 1) % N,
                         m_head, free));
    tag_q.push_back(tag);
    @(posedge clk);
    if (rs) begin
      live_q.delete();
      m_head = 0;
      m_tail = 0;
    end else begin
      for (int i = 0; i < cm; i++) void'(live_q.pop_front());
      m_head = (m_head + cm) % N;
      if (fl) begin
        live_q.delete();
        m_tail = m_head;
      end else begin
        if (g1) begin live_q.push_back(m_tail); m_tail = (m_tail + 1) % N; end
        if (g2) begin live_q.push_back(m_tail); m_tail = (m_tail + 1) % N; end
      end
    end
    #1;
  endtask

  // Monitor: every cycle with a pending expectation is compared at the falling edge.
  always @(negedge clk) begin
    logic [W-1:0] got, exp;
    string        tag;
    if (!proto_ok)
      assert (!(bus.req2_i && !bus.req1_i)) else $error("req2 without req1");
    assert (int'(bus.comnum_i) <= live_q.size()) else $error("commit exceeds occupancy");
    if (exp_q.size() != 0) begin
      exp = exp_q.pop_front();
      tag = tag_q.pop_front();
      got = pack(bus.dp1_o, bus.dp2_o, bus.stall_o, bus.empty_o, bus.full_o,
                 int'(bus.dp1_addr_o), int'(bus.dp2_addr_o), int'(bus.head_o),
                 int'(bus.free_cnt_o));
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got dp1/dp2/stall/empty/full=%b a1=%0d a2=%0d head=%0d free=%0d, expected %b a1=%0d a2=%0d head=%0d free=%0d",
                    tag, got[W-1 -: 5], got[3*S+S : 2*S+S+1], got[2*S+S : S+S+1],
                    got[S+S : S+1], got[S:0], exp[W-1 -: 5], exp[3*S+S : 2*S+S+1],
                    exp[2*S+S : S+S+1], exp[S+S : S+1], exp[S:0]);
    end
  end

  initial begin
    int r1, r2, cm, mx, fl, rs;
    bus.req1_i = 0; bus.req2_i = 0; bus.comnum_i = 0; bus.flush_i = 0;
    @(posedge clk);
    #1;
    // 1: reset then idle
    cycle(0, 0, 0, 0, 1, "reset");
    cycle(0, 0, 0, 0, 0, "idle_after_reset");
    // 2: fill to full, stall, free two, wrap grant
    for (int i = 0; i < 32; i++) cycle(1, 1, 0, 0, 0, "fill_pairs");
    cycle(1, 1, 0, 0, 0, "full_stall");
    cycle(1, 1, 2, 0, 0, "commit_while_full");
    cycle(1, 1, 0, 0, 0, "wrap_grant");
    cycle(0, 0, 0, 0, 0, "after_wrap");
    // 3: one entry left, pair denied, single granted
    cycle(0, 0, 0, 0, 1, "reset");
    for (int i = 0; i < 31; i++) cycle(1, 1, 0, 0, 0, "fill_62");
    cycle(1, 0, 0, 0, 0, "fill_63");
    cycle(1, 1, 0, 0, 0, "pair_no_partial");
    cycle(1, 0, 0, 0, 0, "single_last");
    cycle(0, 0, 0, 0, 0, "full_after_single");
    // 4: full, same-cycle commit is not credited
    cycle(1, 1, 2, 0, 0, "full_commit_no_grant");
    cycle(1, 1, 0, 0, 0, "grant_after_commit");
    cycle(0, 0, 0, 0, 0, "idle_full");
    // 5: head=10 tail=20, flush with commit
    cycle(0, 0, 0, 0, 1, "reset");
    for (int i = 0; i < 10; i++) cycle(1, 1, 0, 0, 0, "alloc_20");
    for (int i = 0; i < 5; i++)  cycle(0, 0, 2, 0, 0, "commit_10");
    cycle(1, 0, 1, 1, 0, "flush_commit");
    cycle(0, 0, 0, 0, 0, "after_flush");
    // 6: protocol error, then reset with traffic in flight
    proto_ok = 1'b1;
    cycle(0, 1, 0, 0, 0, "req2_only");
    cycle(0, 1, 0, 0, 0, "req2_only_again");
    proto_ok = 1'b0;
    for (int i = 0; i < 5; i++) cycle(1, 1, 0, 0, 0, "pre_reset_alloc");
    cycle(1, 1, 1, 1, 1, "reset_overrides");
    cycle(0, 0, 0, 0, 0, "idle_after_midreset");
    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      r1 = ($urandom_range(0, 9) < 7);
      r2 = r1 && ($urandom_range(0, 9) < 6);
      mx = (live_q.size() < 2) ? live_q.size() : 2;
      cm = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(0, mx);
      fl = ($urandom_range(0, 39) == 0);
      rs = ($urandom_range(0, 299) == 0);
      cycle(r1[0], r2[0], cm, fl[0], rs[0], "random");
    end
    cycle(0, 0, 0, 0, 0, "final_idle");
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_chk++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
